sw_debounce: RTL
================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter NB_SW, default 4: number of independent switch channels.
REQ-002 Parameter NB_DEBOUNCE, default 20: width of each per-channel stability counter.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive synchronized cycles required to accept a new level.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port i_reset, input, 1: asynchronous, active-low reset.
REQ-006 Port i_sw, input, NB_SW: raw asynchronous switch pads.
REQ-007 Port o_sw, output, NB_SW: debounced, clock-synchronous switch levels; this port drives the counter/shift-register stage's switch inputs.
REQ-008 Port o_changed, output, NB_SW: one-cycle pulse per channel when its o_sw bit toggles.

Function
REQ-009 Each i_sw bit SHALL pass through a 2-flop synchronizer; the debounce logic SHALL use only the second-flop value s.
REQ-010 Each channel SHALL run a four-state FSM: ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW.
REQ-011 In ST_LOW, s=1 SHALL move to WAIT_HIGH with the counter cleared; s=0 SHALL hold the state.
REQ-012 In WAIT_HIGH, s=0 SHALL return to ST_LOW, counter cleared, and o_sw unchanged (bounce rejected).
REQ-013 In WAIT_HIGH, s=1 with counter = DEBOUNCE_CYCLES-1 SHALL move to ST_HIGH, set o_sw=1, and pulse o_changed for exactly one cycle.
REQ-014 In WAIT_HIGH, s=1 below the limit SHALL increment the counter.
REQ-015 ST_HIGH and WAIT_LOW SHALL mirror REQ-011 to REQ-014 with the levels inverted.
REQ-016 Latency SHALL be DEBOUNCE_CYCLES+3 rising edges from a clean pad edge to the o_sw change: 2 synchronizer edges, 1 edge to enter WAIT, and DEBOUNCE_CYCLES counting edges.
REQ-017 The counter SHALL saturate, never wrap, and SHALL be cleared on every WAIT entry and exit.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each complete with their own latency and pulse.
REQ-019 o_sw and o_changed SHALL be registered outputs with no combinational path from i_sw.

Reset
REQ-020 i_reset=0 SHALL immediately force all synchronizer flops, o_sw and o_changed to 0, and every FSM to ST_LOW with its counter at 0.
REQ-021 Reset asserted mid-WAIT SHALL abandon the pending transition; no o_changed pulse SHALL be produced.
REQ-022 After reset release, a switch held high SHALL be accepted after the normal REQ-016 latency.

Configuration
REQ-023 Macro SW_DEBOUNCE_EDGE_EN, when defined, SHALL add output ports o_rise [NB_SW] and o_fall [NB_SW].
REQ-024 With SW_DEBOUNCE_EDGE_EN, o_rise and o_fall SHALL be one-cycle pulses coincident with o_changed, qualified by the new o_sw level, and reset to 0.
REQ-025 Without SW_DEBOUNCE_EDGE_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Package sw_debounce_pkg SHALL hold the four-state FSM enum typedef and the default parameter constants.
REQ-027 Per-channel logic (synchronizer, FSM, counter) SHALL live in sub-module sw_debounce_channel, instantiated NB_SW times by generate.
REQ-028 Elaboration SHALL fail if DEBOUNCE_CYCLES < 2 or if DEBOUNCE_CYCLES-1 does not fit in NB_DEBOUNCE bits.

Verification (DEBOUNCE_CYCLES=8, NB_SW=4)
REQ-029 Reset release, then i_sw=4'b0001 held -> o_sw[0] rises at edge 11; o_changed[0] high for exactly that one cycle; other bits stay 0.
REQ-030 i_sw[1] toggled high for 5 cycles, low for 2, then held high -> no o_sw[1] change until 11 edges after the final rise.
REQ-031 i_sw=4'b1111 stable high, then all bits dropped on the same edge -> all four o_sw bits fall on edge 11 together, with four simultaneous o_changed pulses.
REQ-032 i_reset pulsed low at cycle 6 of a pending rise -> o_sw and o_changed stay 0 with no pulse; the rise is re-accepted 11 edges after release.
REQ-033 Under SW_DEBOUNCE_EDGE_EN, a rise followed by a fall on bit 2 -> o_rise[2] pulses, then o_fall[2] pulses, each one cycle and each coincident with o_changed[2].

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and default sizing for the switch debouncer.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } sw_state_e;

  localparam int DEF_NB_SW           = 4;
  localparam int DEF_NB_DEBOUNCE     = 20;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/sw_debounce_channel.sv
// One switch channel: 2-flop synchronizer, four-state debounce FSM and
// stability counter, with registered level and change-pulse outputs.
module sw_debounce_channel
  import sw_debounce_pkg::*;
#(
  parameter int NB_DEBOUNCE     = DEF_NB_DEBOUNCE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_changed
);

  localparam logic [NB_DEBOUNCE-1:0] LIMIT   = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_DEBOUNCE-1:0] CNT_ONE = {{(NB_DEBOUNCE-1){1'b0}}, 1'b1};

  logic                   sync1_q, sync2_q;
  sw_state_e              state_q, state_d;
  logic [NB_DEBOUNCE-1:0] cnt_q, cnt_d;
  logic                   sw_q, sw_d;
  logic                   changed_q, changed_d;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      sw_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= i_sw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= changed_d;
    end
  end

  // The counter only advances below LIMIT; reaching LIMIT always leaves
  // WAIT, so it can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sw_d      = sw_q;
    changed_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LIMIT) begin
          state_d   = ST_HIGH;
          cnt_d     = '0;
          sw_d      = 1'b1;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LIMIT) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          sw_d      = 1'b0;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_sw      = sw_q;
  assign o_changed = changed_q;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer. Define SW_DEBOUNCE_EDGE_EN to add the
// o_rise / o_fall edge-pulse outputs.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int NB_SW           = DEF_NB_SW,
  parameter int NB_DEBOUNCE     = DEF_NB_DEBOUNCE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_changed
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall
`endif
);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_min
    $error("sw_debounce: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((longint'(DEBOUNCE_CYCLES) - longint'(1)) >= (longint'(1) << NB_DEBOUNCE)) begin : g_chk_fit
    $error("sw_debounce: DEBOUNCE_CYCLES-1 does not fit in NB_DEBOUNCE bits");
  end

  for (genvar g = 0; g < NB_SW; g++) begin : g_ch
    sw_debounce_channel #(
      .NB_DEBOUNCE    (NB_DEBOUNCE),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_sw     (i_sw[g]),
      .o_sw     (o_sw[g]),
      .o_changed(o_changed[g])
    );
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Both operands are flop outputs, so the edge pulses stay free of i_sw paths.
  assign o_rise = o_changed & o_sw;
  assign o_fall = o_changed & ~o_sw;
`endif

endmodule
